fifo_burst_reader: RTL

//  Read-side master for the 16x8 byte FIFO: on a command, drains exactly LEN bytes through the FIFO

---
 rtl/fifo_burst_reader_pkg.sv | 16 +
 rtl/fifo_skid_buf.sv | 72 +++++++
 rtl/fifo_burst_reader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared constants and state encoding for the FIFO burst reader.
// Imported by the top and by the skid buffer.
package fifo_burst_reader_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register FIFO that absorbs bytes landing from the FIFO read port.
// Entry 0 is always the head; simultaneous push and pop leave occupancy unchanged.
module fifo_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ
);

    localparam logic [1:0] FULL = 2'(SKID_DEPTH);

    logic [DATA_W-1:0] mem0_q, mem0_d;
    logic [DATA_W-1:0] mem1_q, mem1_d;
    logic [1:0]        occ_q, occ_d;

    always_comb begin
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        occ_d  = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else if (push && pop) begin
            if (occ_q == 2'd0) begin
                mem0_d = push_data;
                occ_d  = 2'd1;
            end else if (occ_q == 2'd1) begin
                mem0_d = push_data;
            end else begin
                mem0_d = mem1_q;
                mem1_d = push_data;
            end
        end else if (push) begin
            if (occ_q == 2'd0) begin
                mem0_d = push_data;
            end else begin
                mem1_d = push_data;
            end
            if (occ_q != FULL) begin
                occ_d = occ_q + 2'd1;
            end
        end else if (pop && occ_q != 2'd0) begin
            mem0_d = mem1_q;
            occ_d  = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem0_q <= '0;
            mem1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            occ_q  <= occ_d;
        end
    end

    assign valid = (occ_q != 2'd0);
    assign head  = mem0_q;
    assign occ   = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains LEN bytes from the FIFO read port onto a valid/ready byte stream with last,
// hiding the FIFO's one-cycle read latency behind a two-entry skid buffer.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [1:0]        dbg_state
);

    // Stream handshake: a byte moves when m_valid & m_ready at posedge clk; while
    // m_valid is high and m_ready low, m_data and m_last hold their values.

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]   out_cnt_q, out_cnt_d;
    logic               inflight_q, inflight_d;
    logic               aborted_q, aborted_d;

    logic               skid_valid;
    logic [DATA_W-1:0]  skid_head;
    logic [1:0]         skid_occ;
    logic               skid_push;
    logic               skid_flush;
    logic               hs;
    logic               last_beat;
    logic               active;
    logic               abort_eff;
    logic [2:0]         pending;
    logic               credit;
    logic               skid_empty_next;

    assign hs        = skid_valid && m_ready;
    assign last_beat = skid_valid && (out_cnt_q == len_q - LEN_W'(1));
    assign active    = (state_q == READ) || (state_q == DRAIN);
    // An abort that coincides with the final handshake loses to it: the burst ends normally.
    assign abort_eff = abort && active && !(hs && last_beat);

    // A byte popped this cycle frees its slot in time for a byte issued this cycle.
    assign pending = {1'b0, skid_occ} + {2'b00, inflight_q} - {2'b00, hs};
    assign credit  = (pending < 3'(SKID_DEPTH));

    assign fifo_rd_en = (state_q == READ) && !fifo_empty && (issue_cnt_q != '0)
                        && credit && !abort_eff;

    assign skid_push  = inflight_q && !abort_eff;
    assign skid_flush = abort_eff;
    assign skid_empty_next = ((skid_occ == 2'd0) && !skid_push)
                          || ((skid_occ == 2'd1) && hs && !skid_push);

    fifo_skid_buf #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (skid_flush),
        .push      (skid_push),
        .push_data (fifo_data),
        .pop       (hs),
        .valid     (skid_valid),
        .head      (skid_head),
        .occ       (skid_occ)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        inflight_d  = fifo_rd_en;
        aborted_d   = aborted_q;

        if (fifo_rd_en) begin
            issue_cnt_d = issue_cnt_q - LEN_W'(1);
        end
        if (hs) begin
            out_cnt_d = out_cnt_q + LEN_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = len;
                    issue_cnt_d = len;
                    out_cnt_d   = '0;
                    aborted_d   = 1'b0;
                    state_d     = (len != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (abort_eff) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (issue_cnt_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_eff) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (!inflight_q && skid_empty_next) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= inflight_d;
            aborted_q   <= aborted_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign aborted   = (state_q == DONE) && aborted_q;
    assign m_valid   = skid_valid;
    assign m_data    = skid_head;
    assign m_last    = last_beat;
    assign dbg_state = state_q;

endmodule
